// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM request arbiter.
package sdram_pkg;

  // Command word exchanged with requesters and with the SDRAM controller.
  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Only READ and WRITE count as a request; NOP and the reserved code do not.
  function automatic logic is_request(logic [1:0] c);
    return (c == CMD_WRITE) || (c == CMD_READ);
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin pick: search starts one past the previous owner and wraps.
module round_robin_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] w_j;

  // Walk the search order backwards so the earliest hit is the last write.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = '0;
    for (int k = N; k >= 1; k--) begin
      w_j = IW'((int'(i_last) + k) % N);
      if (i_req[w_j]) begin
        o_grant      = '0;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
        o_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Multi-requester front end for a single SDRAM controller: one transaction
// at a time, round-robin between requesters, completion beats routed back.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_REQUESTERS    = 2,
  parameter int READ_BURST_LENGTH = 1,
  parameter int WRITE_BURST       = 1,
  parameter int ADDRESS_WIDTH     = 22,
  parameter int DATA_WIDTH        = 16
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_REQUESTERS-1:0][1:0]               req_command,
  input  logic [NUM_REQUESTERS-1:0][ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0]    req_write_data,
  output logic [NUM_REQUESTERS-1:0]                    req_grant,
  output logic [DATA_WIDTH-1:0]                        req_read_data,
  output logic [NUM_REQUESTERS-1:0]                    req_read_valid,
  output logic [NUM_REQUESTERS-1:0]                    req_write_done,
  output logic [1:0]                                   command,
  output logic [ADDRESS_WIDTH-1:0]                     data_address,
  output logic [DATA_WIDTH-1:0]                        data_write,
  input  logic [DATA_WIDTH-1:0]                        data_read,
  input  logic                                         data_read_valid,
  input  logic                                         data_write_done
);

  localparam int IW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  // Beat counter value on the final beat of each transaction type.
  localparam logic [2:0] RD_LAST = 3'(READ_BURST_LENGTH - 1);
  localparam logic [2:0] WR_LAST = (WRITE_BURST != 0) ? RD_LAST : 3'd0;

  state_e                    r_state;
  cmd_e                      r_cmd;
  cmd_e                      r_cmd_out;
  logic [IW-1:0]             r_owner;
  logic [IW-1:0]             r_last;
  logic [ADDRESS_WIDTH-1:0]  r_addr;
  logic [NUM_REQUESTERS-1:0] r_grant;
  logic [2:0]                r_beats;

  logic [NUM_REQUESTERS-1:0] w_req;
  logic [NUM_REQUESTERS-1:0] w_gnt;
  logic [IW-1:0]             w_idx;
  logic                      w_any;
  logic                      w_rd_beat;
  logic                      w_wr_beat;
  logic                      w_beat;
  logic                      w_last;
  logic [NUM_REQUESTERS-1:0] w_owner_oh;

  // Request vector: which requesters present a real command.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) w_req[i] = is_request(req_command[i]);
  end

  round_robin_arbiter #(.N(NUM_REQUESTERS), .IW(IW)) u_rr (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_grant (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  // Only beats matching the in-flight command count; everything else is noise.
  assign w_rd_beat  = (r_state == ST_ACTIVE) && (r_cmd == CMD_READ)  && data_read_valid;
  assign w_wr_beat  = (r_state == ST_ACTIVE) && (r_cmd == CMD_WRITE) && data_write_done;
  assign w_beat     = w_rd_beat || w_wr_beat;
  assign w_last     = w_beat && (r_beats == ((r_cmd == CMD_READ) ? RD_LAST : WR_LAST));
  assign w_owner_oh = NUM_REQUESTERS'(1) << r_owner;

  assign req_read_valid = w_rd_beat ? w_owner_oh : '0;
  assign req_write_done = w_wr_beat ? w_owner_oh : '0;
  assign req_read_data  = data_read;
  // Write data stays live so the owner can step through its burst words.
  assign data_write     = req_write_data[r_owner];
  assign command        = r_cmd_out;
  assign data_address   = r_addr;
  assign req_grant      = r_grant;

  // Transaction FSM: arbitrate in IDLE, count beats in ACTIVE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cmd     <= CMD_NOP;
      r_cmd_out <= CMD_NOP;
      r_owner   <= '0;
      r_last    <= IW'(NUM_REQUESTERS - 1);
      r_addr    <= '0;
      r_grant   <= '0;
      r_beats   <= '0;
    end else begin
      r_grant <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner   <= w_idx;
            r_cmd     <= cmd_e'(req_command[w_idx]);
            r_cmd_out <= cmd_e'(req_command[w_idx]);
            r_addr    <= req_address[w_idx];
            r_grant   <= w_gnt;
            r_beats   <= '0;
            r_state   <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (w_beat) begin
            // Controller has accepted the command once any beat arrives.
            r_cmd_out <= CMD_NOP;
            if (w_last) begin
              r_state <= ST_IDLE;
              r_last  <= r_owner;
              r_beats <= '0;
            end else begin
              r_beats <= r_beats + 3'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 2, number of requester ports (2..8).
REQ-002 SHALL have parameter READ_BURST_LENGTH, default 1, read beats per transaction (1, 2, 4, 8).
REQ-003 SHALL have parameter WRITE_BURST, default 1, 1 = writes take READ_BURST_LENGTH beats, 0 = 1 beat.
REQ-004 SHALL have parameter ADDRESS_WIDTH, default 22, word address width.
REQ-005 SHALL have parameter DATA_WIDTH, default 16, data word width.
REQ-006 SHALL have one clock; reset is synchronous and active-high. Ports: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-007 SHALL have req_command, input, [NUM_REQUESTERS][2], per-requester command.
REQ-008 SHALL have req_address, input, [NUM_REQUESTERS][ADDRESS_WIDTH], per-requester address.
REQ-009 SHALL have req_write_data, input, [NUM_REQUESTERS][DATA_WIDTH], per-requester live write word.
REQ-010 SHALL have req_grant, output, NUM_REQUESTERS, one-cycle pulse: request captured.
REQ-011 SHALL have req_read_data, output, DATA_WIDTH, broadcast read word.
REQ-012 SHALL have req_read_valid, output, NUM_REQUESTERS, read beat valid for owner only.
REQ-013 SHALL have req_write_done, output, NUM_REQUESTERS, write beat consumed by owner only.
REQ-014 SHALL have the controller-side ports: command output 2; data_address output ADDRESS_WIDTH; data_write output DATA_WIDTH; data_read input DATA_WIDTH; data_read_valid input 1; data_write_done input 1.

Function
REQ-015 SHALL use command encoding 0 = NOP, 1 = WRITE, 2 = READ, 3 = reserved; a requester presenting 0 or 3 is not requesting.
REQ-016 SHALL have states IDLE and ACTIVE; in IDLE, command = NOP.
REQ-017 SHALL arbitrate in IDLE, round-robin: search starts at last_owner+1 (mod NUM_REQUESTERS) and picks the first requester with a valid command.
REQ-018 SHALL, on the IDLE clock edge with a winner: register owner, command, address; pulse req_grant[owner] for the following cycle; enter ACTIVE.
REQ-019 SHALL present the registered command and address to the controller from the first ACTIVE cycle.
REQ-020 SHALL hold the command until the first data_read_valid or data_write_done beat, then drive NOP for the rest of the transaction.
REQ-021 SHALL drive data_write combinationally from req_write_data[owner] throughout ACTIVE; the requester advances its word after each req_write_done.
REQ-022 SHALL route data_read_valid/data_write_done to the owner bit only, same cycle; req_read_data = data_read.
REQ-023 SHALL count beats with a 0..7 counter; the transaction ends on beat READ_BURST_LENGTH (read) or the write beat count per REQ-003.
REQ-024 SHALL, on the last beat, enter IDLE with last_owner = owner; arbitration is never done in the same cycle, giving one NOP cycle between transactions.
REQ-025 SHALL ignore completion beats of the wrong type for the current command and beats received in IDLE.
REQ-026 SHALL latch a requester's inputs only at grant; inputs changing afterwards have no effect except write data.

Reset
REQ-027 SHALL, on reset, set: state IDLE; command NOP; data_address 0; req_grant 0; beat counter 0; last_owner NUM_REQUESTERS-1, so requester 0 has priority.
REQ-028 SHALL, on reset mid-transaction, abandon the transaction without flushing the controller; the system resets both together.

Structure
REQ-029 SHALL place the command encoding enum and state enum in shared package sdram_pkg.
REQ-030 SHALL use one sub-module, round_robin_arbiter, taking request vector and last_owner and returning one-hot grant and index.

Verification
REQ-031 SHALL cover a single read, burst 4, requester 0 at address 0x00123: grant pulse, command=2 until first valid, 4 req_read_valid[0] pulses, then IDLE.
REQ-032 SHALL cover simultaneous writes from requesters 0 and 1 after reset: 0 is served first, 1 next, with exactly one NOP cycle between.
REQ-033 SHALL cover a continuous request from requester 1 with requester 0 idle: back-to-back grants to 1, with no starvation when requester 0 later requests (alternation).
REQ-034 SHALL cover reset asserted during beat 2 of a 4-beat read: next cycle command=NOP, no grants, last_owner=1.
REQ-035 SHALL cover req_command=3: never granted; command stays NOP.
REQ-036 SHALL cover a stray data_read_valid during a write: ignored, no req_read_valid, no beat count change.
